sevenseg_scan: RTL and testbench

- Parametrised, time-multiplexed multi-digit seven-segment driver; successor to the single-digit combinational BCD decoder.
- Holds NUM_DIGITS packed BCD digits and scans them onto one shared segment bus with one-hot digit enables.
- Data is double-buffered: new values are committed only at frame boundaries, so a frame never mixes old and new digits.
- Sits between the datapath or counter logic and the board display pins.

---
 rtl/sevenseg_pkg.sv | 40 ++++
 rtl/bcd7_decode.sv | 27 ++
 rtl/sevenseg_scan.sv | 133 +++++++++++++
 tb/tb_sevenseg_scan.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants for the multiplexed seven-segment driver: segment bit
// positions, digit codes and the counter width helper.
package sevenseg_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   function automatic logic [6:0] seg_bit(input int pos);
      return 7'b000_0001 << pos;
   endfunction

   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_0 = seg_bit(SEG_A) | seg_bit(SEG_B) | seg_bit(SEG_C) |
                                  seg_bit(SEG_D) | seg_bit(SEG_E) | seg_bit(SEG_F);
   localparam logic [6:0] SEG_1 = seg_bit(SEG_B) | seg_bit(SEG_C);
   localparam logic [6:0] SEG_2 = seg_bit(SEG_A) | seg_bit(SEG_B) | seg_bit(SEG_D) |
                                  seg_bit(SEG_E) | seg_bit(SEG_G);
   localparam logic [6:0] SEG_3 = seg_bit(SEG_A) | seg_bit(SEG_B) | seg_bit(SEG_C) |
                                  seg_bit(SEG_D) | seg_bit(SEG_G);
   localparam logic [6:0] SEG_4 = seg_bit(SEG_B) | seg_bit(SEG_C) | seg_bit(SEG_F) |
                                  seg_bit(SEG_G);
   localparam logic [6:0] SEG_5 = seg_bit(SEG_A) | seg_bit(SEG_C) | seg_bit(SEG_D) |
                                  seg_bit(SEG_F) | seg_bit(SEG_G);
   localparam logic [6:0] SEG_6 = seg_bit(SEG_A) | seg_bit(SEG_C) | seg_bit(SEG_D) |
                                  seg_bit(SEG_E) | seg_bit(SEG_F) | seg_bit(SEG_G);
   localparam logic [6:0] SEG_7 = seg_bit(SEG_A) | seg_bit(SEG_B) | seg_bit(SEG_C);
   localparam logic [6:0] SEG_8 = SEG_0 | seg_bit(SEG_G);
   localparam logic [6:0] SEG_9 = seg_bit(SEG_A) | seg_bit(SEG_B) | seg_bit(SEG_C) |
                                  seg_bit(SEG_D) | seg_bit(SEG_F) | seg_bit(SEG_G);

endpackage

// File: rtl/bcd7_decode.sv
// Combinational BCD to seven-segment decode, active-high {G..A};
// codes above 9 produce a blank pattern.
module bcd7_decode
   import sevenseg_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed NUM_DIGITS seven-segment driver with a shadow register
// committed at frame boundaries. Define SEVENSEG_SCAN_LZB_EN for leading-zero blanking.
module sevenseg_scan
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 1000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   output logic                    load_ack,
   output logic                    pending,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic [6:0]              sevenseg_out,
   output logic                    dp_out
);

   localparam int IW = cnt_width(NUM_DIGITS);
   localparam int PW = cnt_width(REFRESH_DIV);

   logic [PW-1:0]           presc;
   logic [IW-1:0]           idx;
   logic                    presc_tc;
   logic                    frame_end;
   logic [4*NUM_DIGITS-1:0] shadow_bcd;
   logic [NUM_DIGITS-1:0]   shadow_dp;
   logic [4*NUM_DIGITS-1:0] disp_bcd;
   logic [NUM_DIGITS-1:0]   disp_dp;
   logic [3:0]              cur_bcd;
   logic                    cur_dp;
   logic [NUM_DIGITS-1:0]   cur_onehot;
   logic [6:0]              dec_seg;
   logic [6:0]              seg_next;

   assign presc_tc  = (presc == PW'(REFRESH_DIV - 1));
   assign frame_end = presc_tc && (idx == IW'(NUM_DIGITS - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc <= '0;
         idx   <= '0;
      end else if (presc_tc) begin
         presc <= '0;
         idx   <= frame_end ? '0 : idx + 1'b1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // A load on the boundary cycle lands in the shadow after the old shadow
   // has been committed, so pending must stay set for the next frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow_bcd <= '0;
         shadow_dp  <= '0;
         disp_bcd   <= '0;
         disp_dp    <= '0;
         pending    <= 1'b0;
         load_ack   <= 1'b0;
      end else begin
         load_ack <= 1'b0;
         if (frame_end && pending) begin
            disp_bcd <= shadow_bcd;
            disp_dp  <= shadow_dp;
            load_ack <= 1'b1;
            pending  <= 1'b0;
         end
         if (load) begin
            shadow_bcd <= bcd_in;
            shadow_dp  <= dp_in;
            pending    <= 1'b1;
         end
      end
   end

   always_comb begin
      cur_bcd    = 4'd0;
      cur_dp     = 1'b0;
      cur_onehot = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IW'(i)) begin
            cur_bcd       = disp_bcd[4*i +: 4];
            cur_dp        = disp_dp[i];
            cur_onehot[i] = 1'b1;
         end
      end
   end

   bcd7_decode u_dec (
      .bcd (cur_bcd),
      .seg (dec_seg)
   );

`ifdef SEVENSEG_SCAN_LZB_EN
   logic [NUM_DIGITS-1:0] lz_mask;
   logic                  lz_run;

   // Blank mask follows the display register only, so it moves at commit.
   always_comb begin
      lz_mask = '0;
      lz_run  = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         lz_run     = lz_run && (disp_bcd[4*i +: 4] == 4'd0);
         lz_mask[i] = lz_run;
      end
   end

   assign seg_next = (|(lz_mask & cur_onehot)) ? SEG_BLANK : dec_seg;
`else
   assign seg_next = dec_seg;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         digit_en     <= '0;
         sevenseg_out <= 7'h00;
         dp_out       <= 1'b0;
      end else if (enable) begin
         digit_en     <= cur_onehot;
         sevenseg_out <= seg_next;
         dp_out       <= cur_dp;
      end else begin
         digit_en     <= '0;
         sevenseg_out <= 7'h00;
         dp_out       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan with NUM_DIGITS=4, REFRESH_DIV=4
// (16 clocks per frame); works with or without SEVENSEG_SCAN_LZB_EN.
module tb_sevenseg_scan;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        load;
   logic [15:0] bcd_in;
   logic [3:0]  dp_in;
   logic        load_ack;
   logic        pending;
   logic [3:0]  digit_en;
   logic [6:0]  sevenseg_out;
   logic        dp_out;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic pend_m   = 1'b0;

`ifdef SEVENSEG_SCAN_LZB_EN
   localparam logic [6:0] Z_HI = 7'h00;
`else
   localparam logic [6:0] Z_HI = 7'h3F;
`endif

   sevenseg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .load         (load),
      .bcd_in       (bcd_in),
      .dp_in        (dp_in),
      .load_ack     (load_ack),
      .pending      (pending),
      .digit_en     (digit_en),
      .sevenseg_out (sevenseg_out),
      .dp_out       (dp_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_off(input string tag);
      chk({tag, ".digit_en"}, 32'(digit_en), 32'h0);
      chk({tag, ".seg"}, 32'(sevenseg_out), 32'h0);
      chk({tag, ".dp"}, 32'(dp_out), 32'h0);
   endtask

   // One full frame starting at a frame boundary. segs = {s3,s2,s1,s0}.
   task automatic run_frame(input string tag, input logic [27:0] segs, input logic [3:0] dps,
                            input int la, input logic [15:0] lb, input logic [3:0] ld,
                            input int la2, input logic [15:0] lb2, input logic [3:0] ld2);
      int         d;
      logic [3:0] en_exp;
      logic       ld_now;
      logic       ack_exp;
      for (int i = 0; i < 16; i++) begin
         ld_now = load;
         step();
         d       = i / 4;
         en_exp  = 4'b0001 << d;
         ack_exp = (i == 15) ? pend_m : 1'b0;
         if (i == 15)
            pend_m = ld_now;
         else if (ld_now)
            pend_m = 1'b1;
         chk({tag, ".digit_en"}, 32'(digit_en), 32'(en_exp));
         chk({tag, ".seg"}, 32'(sevenseg_out), 32'(segs[7*d +: 7]));
         chk({tag, ".dp"}, 32'(dp_out), 32'(dps[d]));
         chk({tag, ".load_ack"}, 32'(load_ack), 32'(ack_exp));
         chk({tag, ".pending"}, 32'(pending), 32'(pend_m));
         load = 1'b0;
         if (i == la) begin
            load = 1'b1; bcd_in = lb; dp_in = ld;
         end
         if (i == la2) begin
            load = 1'b1; bcd_in = lb2; dp_in = ld2;
         end
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      enable = 1'b1;
      load   = 1'b0;
      bcd_in = 16'h0;
      dp_in  = 4'h0;

      repeat (3) step();
      chk_off("reset");
      chk("reset.pending", 32'(pending), 32'h0);
      chk("reset.load_ack", 32'(load_ack), 32'h0);

      rst_n = 1'b1;
      run_frame("scan0", {Z_HI, Z_HI, Z_HI, 7'h3F}, 4'b0000, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
      run_frame("load1234", {Z_HI, Z_HI, Z_HI, 7'h3F}, 4'b0000, 5, 16'h1234, 4'h0, -1, 16'h0, 4'h0);
      run_frame("show1234_dbl", {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000,
                2, 16'h1111, 4'h0, 8, 16'h2222, 4'h0);
      run_frame("show2222_coll", {7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'b0000,
                3, 16'h0987, 4'h0, 14, 16'hA9F0, 4'b0100);
      run_frame("show0987", {Z_HI, 7'h6F, 7'h7F, 7'h07}, 4'b0000, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
      run_frame("showA9F0", {7'h00, 7'h6F, 7'h00, 7'h3F}, 4'b0100, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

      // enable low for edges 1..9, back on from edge 10 (index 2)
      enable = 1'b0;
      step();
      chk_off("en_off_first");
      repeat (8) step();
      chk_off("en_off_idx2");
      enable = 1'b1;
      step();
      chk("en_on.digit_en", 32'(digit_en), 32'h4);
      chk("en_on.seg", 32'(sevenseg_out), 32'h6F);
      chk("en_on.dp", 32'(dp_out), 32'h1);
      repeat (3) step();
      chk("en_on_idx3.digit_en", 32'(digit_en), 32'h8);
      chk("en_on_idx3.seg", 32'(sevenseg_out), 32'h00);
      repeat (3) step();

      // reset while a load is pending and index 2 is active
      load = 1'b1; bcd_in = 16'h5678; dp_in = 4'hF;
      step();
      load = 1'b0;
      chk("rst_mid.pending_set", 32'(pending), 32'h1);
      repeat (9) step();
      chk("rst_mid.idx2", 32'(digit_en), 32'h4);
      rst_n = 1'b0;
      step();
      chk_off("rst_mid");
      chk("rst_mid.pending", 32'(pending), 32'h0);
      chk("rst_mid.load_ack", 32'(load_ack), 32'h0);
      rst_n  = 1'b1;
      pend_m = 1'b0;
      run_frame("post_rst", {Z_HI, Z_HI, Z_HI, 7'h3F}, 4'b0000, 0, 16'h0050, 4'h0, -1, 16'h0, 4'h0);
      run_frame("show0050", {Z_HI, Z_HI, 7'h6D, 7'h3F}, 4'b0000, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
